// File: rtl/pico_stream_pkg.sv
// pico_stream_pkg: shared tag helpers, endpoint reset sequence values and scheduler FSM states.
// No ports; imported by the scheduler, its interface and the shadow register file.
package pico_stream_pkg;
    localparam int TAG_W          = 9;
    localparam int TAG_DESC_BIT   = 8;
    localparam int TAG_ACTIVE_BIT = 7;
    localparam logic [31:0] RST_SEQ_DATA = 32'h2000;
    localparam logic [31:0] RST_SEQ_DESC = 32'h200;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_REPORT,
        ST_POP,
        ST_HOLD
    } state_t;
    function automatic logic [TAG_W-1:0] make_tag(input logic desc, input logic [6:0] id7);
        logic [TAG_W-1:0] t;
        t = {2'b00, id7};
        t[TAG_DESC_BIT] = desc;
        t[TAG_ACTIVE_BIT] = 1'b1;
        return t;
    endfunction
endpackage

// File: rtl/pico_stream_poll_sched_if.sv
// pico_stream_poll_sched_if: endpoint poll, descriptor pop and host update signals of the poll scheduler.
// master = scheduler side (drives poll/pop tags and updates), slave = endpoint/host side.
interface pico_stream_poll_sched_if;
    import pico_stream_pkg::*;
    logic             enable;
    logic [TAG_W-1:0] s_poll_id;
    logic [31:0]      s_poll_seq;
    logic [127:0]     s_poll_next_desc;
    logic             s_poll_next_desc_valid;
    logic [TAG_W-1:0] s_next_desc_rd_id;
    logic             s_next_desc_rd_en;
    logic             upd_valid;
    logic             upd_rdy;
    logic [TAG_W-1:0] upd_id;
    logic [31:0]      upd_seq;
    logic [127:0]     upd_desc;
    logic             upd_desc_valid;
    modport master (
        input  enable, s_poll_seq, s_poll_next_desc, s_poll_next_desc_valid, upd_rdy,
        output s_poll_id, s_next_desc_rd_id, s_next_desc_rd_en,
               upd_valid, upd_id, upd_seq, upd_desc, upd_desc_valid
    );
    modport slave (
        output enable, s_poll_seq, s_poll_next_desc, s_poll_next_desc_valid, upd_rdy,
        input  s_poll_id, s_next_desc_rd_id, s_next_desc_rd_en,
               upd_valid, upd_id, upd_seq, upd_desc, upd_desc_valid
    );
endinterface

// File: rtl/pico_poll_shadow.sv
// pico_poll_shadow: last-reported sequence per tag, entry 2*k = data tag, 2*k+1 = desc tag of stream k.
// Ports: clk, rst (async), rd_addr_i/rd_data_o combinational read, we_i/wr_addr_i/wr_data_i write.
module pico_poll_shadow
    import pico_stream_pkg::*;
#(
    parameter int NUM_STREAMS = 4,
    parameter int AW          = $clog2(2 * NUM_STREAMS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o,
    input  logic          we_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [31:0]   wr_data_i
);
    localparam int DEPTH = 2 * NUM_STREAMS;
    logic [31:0] mem_q [DEPTH];
    assign rd_data_o = mem_q[rd_addr_i];
    // Reset to the endpoints' own reset counters so an untouched stream never reports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= i[0] ? RST_SEQ_DESC : RST_SEQ_DATA;
        end else if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end
endmodule

// File: rtl/pico_stream_poll_sched.sv
// pico_stream_poll_sched: round-robin poller that reports endpoint sequence changes and pops head descriptors.
// Ports: clk, rst (async, active-high), bus (master modport: enable, poll, pop and host update signals).
module pico_stream_poll_sched
    import pico_stream_pkg::*;
#(
    parameter int NUM_STREAMS = 4,
    parameter int FIRST_ID    = 1
) (
    input  logic clk,
    input  logic rst,
    pico_stream_poll_sched_if.master bus
);
    localparam int IW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam int AW = IW + 1;
    state_t       state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, idx_nx;
    logic         sel_q, sel_d;
    logic [1:0]   hold_q, hold_d;
    logic [8:0]   upd_id_q, upd_id_d;
    logic [31:0]  upd_seq_q, upd_seq_d;
    logic [127:0] upd_desc_q, upd_desc_d;
    logic         upd_dv_q, upd_dv_d;
    logic [6:0]   id7;
    logic [8:0]   cur_tag, data_tag;
    logic [31:0]  shadow_seq;
    logic         shadow_we, adv, cap_dv;
    assign id7      = 7'(FIRST_ID) + 7'(idx_q);
    assign cur_tag  = make_tag(sel_q, id7);
    assign data_tag = make_tag(1'b0, id7);
    assign idx_nx   = (idx_q == IW'(NUM_STREAMS - 1)) ? '0 : idx_q + 1'b1;
    // Head descriptors only belong to data-tag polls.
    assign cap_dv   = !sel_q && bus.s_poll_next_desc_valid;
    pico_poll_shadow #(.NUM_STREAMS(NUM_STREAMS), .AW(AW)) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_i ({idx_q, sel_q}),
        .rd_data_o (shadow_seq),
        .we_i      (shadow_we),
        .wr_addr_i ({idx_q, sel_q}),
        .wr_data_i (upd_seq_q)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            sel_q      <= 1'b0;
            hold_q     <= '0;
            upd_id_q   <= '0;
            upd_seq_q  <= '0;
            upd_desc_q <= '0;
            upd_dv_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            hold_q     <= hold_d;
            upd_id_q   <= upd_id_d;
            upd_seq_q  <= upd_seq_d;
            upd_desc_q <= upd_desc_d;
            upd_dv_q   <= upd_dv_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sel_d      = sel_q;
        hold_d     = hold_q;
        upd_id_d   = upd_id_q;
        upd_seq_d  = upd_seq_q;
        upd_desc_d = upd_desc_q;
        upd_dv_d   = upd_dv_q;
        shadow_we  = 1'b0;
        adv        = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = bus.enable ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                upd_id_d   = cur_tag;
                upd_seq_d  = bus.s_poll_seq;
                upd_desc_d = sel_q ? '0 : bus.s_poll_next_desc;
                upd_dv_d   = cap_dv;
                if (bus.s_poll_seq != shadow_seq || cap_dv) state_d = ST_REPORT;
                else adv = 1'b1;
            end
            ST_REPORT: begin
                if (bus.upd_rdy) begin
                    shadow_we = 1'b1;
                    if (upd_dv_q) state_d = ST_POP;
                    else adv = 1'b1;
                end
            end
            ST_POP: begin
                hold_d  = '0;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_q == 2'd2) adv = 1'b1;
                else hold_d = hold_q + 2'd1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Advance: data tag -> desc tag of the same stream, desc tag -> data tag of the next stream.
        if (adv) begin
            sel_d   = !sel_q;
            idx_d   = sel_q ? idx_nx : idx_q;
            state_d = bus.enable ? ST_ISSUE : ST_IDLE;
        end
    end
    assign bus.s_poll_id         = (state_q == ST_ISSUE) ? cur_tag : '0;
    assign bus.s_next_desc_rd_en = (state_q == ST_POP);
    assign bus.s_next_desc_rd_id = (state_q == ST_POP) ? data_tag : '0;
    assign bus.upd_valid         = (state_q == ST_REPORT);
    assign bus.upd_id            = upd_id_q;
    assign bus.upd_seq           = upd_seq_q;
    assign bus.upd_desc          = upd_desc_q;
    assign bus.upd_desc_valid    = upd_dv_q;
endmodule

// File: tb/tb_pico_stream_poll_sched.sv
// tb_pico_stream_poll_sched: randomized scoreboard bench with an endpoint model and a poll-order/shadow reference.
module tb_pico_stream_poll_sched;
    localparam int NS  = 4;
    localparam int FID = 1;
    localparam int NP  = 2 * NS;
    typedef struct packed {
        logic [8:0]   id;
        logic [31:0]  seq;
        logic [127:0] desc;
        logic         dv;
    } upd_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    pico_stream_poll_sched_if bus ();
    pico_stream_poll_sched #(.NUM_STREAMS(NS), .FIRST_ID(FID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    int checks = 0;
    int failures = 0;
    upd_t exp_q[$];
    logic [31:0]  data_seq [NS];
    logic [31:0]  desc_seq [NS];
    logic         head_v [NS];
    logic [127:0] head_desc [NS];
    logic [31:0]  sh [NP];
    int p = 0;
    int rdy_mode = 0;
    bit mut_en = 0;
    bit rand_en = 0;
    bit en_steady = 1;
    int ep_k;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask
    // Endpoint: registered response to whichever tag was polled, held until the next poll.
    always @(posedge clk) begin
        if (bus.s_poll_id != 9'h0) begin
            ep_k = int'(bus.s_poll_id[6:0]) - FID;
            if (ep_k >= 0 && ep_k < NS) begin
                bus.s_poll_seq <= bus.s_poll_id[8] ? desc_seq[ep_k] : data_seq[ep_k];
                bus.s_poll_next_desc <= head_desc[ep_k];
                bus.s_poll_next_desc_valid <= head_v[ep_k];
            end
        end
    end
    task automatic reset_model();
        for (int i = 0; i < NP; i++) sh[i] = (i % 2 == 1) ? 32'h200 : 32'h2000;
        p = 0;
        exp_q.delete();
    endtask
    // Reference: polls visit tags in a fixed round; an update is due whenever the polled value
    // differs from the last value reported for that tag, or a data poll finds a head descriptor.
    task automatic poll_model();
        int k;
        bit d;
        logic [8:0] et;
        upd_t e;
        k = p / 2;
        d = (p % 2 == 1);
        et = {d, 1'b1, 7'(FID + k)};
        chk("poll_tag", 128'(bus.s_poll_id), 128'(et));
        e.id = et;
        e.seq = d ? desc_seq[k] : data_seq[k];
        e.dv = !d && head_v[k];
        e.desc = d ? 128'h0 : head_desc[k];
        if (e.seq != sh[p] || e.dv) exp_q.push_back(e);
        sh[p] = e.seq;
        p = (p + 1) % NP;
    endtask
    task automatic mutate();
        int k;
        k = $urandom_range(0, NS - 1);
        case ($urandom_range(0, 3))
            0: data_seq[k] = data_seq[k] + $urandom_range(1, 16);
            1: desc_seq[k] = desc_seq[k] + 1;
            2: begin
                head_v[k] = 1'b1;
                head_desc[k] = {$urandom, $urandom, $urandom, $urandom};
            end
            default: data_seq[k] = $urandom;
        endcase
    endtask
    task automatic step();
        int k;
        @(negedge clk);
        if (mut_en && $urandom_range(0, 5) == 0) mutate();
        if (rand_en) bus.enable = ($urandom_range(0, 3) != 0);
        bus.upd_rdy = (rdy_mode == 1) ? 1'b0 : (rdy_mode == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (bus.s_next_desc_rd_en) begin
            k = int'(bus.s_next_desc_rd_id[6:0]) - FID;
            if (k >= 0 && k < NS) head_v[k] = 1'b0;
        end
        if (bus.upd_valid) chk("no_poll_in_report", 128'(bus.s_poll_id), 128'h0);
        if (bus.s_poll_id != 9'h0) poll_model();
    endtask
    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_poll_id"}, 128'(bus.s_poll_id), 128'h0);
        chk({tag, "_rd_id"}, 128'(bus.s_next_desc_rd_id), 128'h0);
        chk({tag, "_rd_en"}, 128'(bus.s_next_desc_rd_en), 128'h0);
        chk({tag, "_upd_valid"}, 128'(bus.upd_valid), 128'h0);
        chk({tag, "_upd_id"}, 128'(bus.upd_id), 128'h0);
        chk({tag, "_upd_seq"}, 128'(bus.upd_seq), 128'h0);
        chk({tag, "_upd_desc"}, bus.upd_desc, 128'h0);
        chk({tag, "_upd_dv"}, 128'(bus.upd_desc_valid), 128'h0);
    endtask
    // Monitor: pops the scoreboard when an update is presented and tracks pop/hold timing.
    bit pend = 0;
    bit pop_due = 0;
    bit pop_off = 0;
    int pop_cyc = -1;
    int cyc = 0;
    logic [8:0] exp_pop_id;
    upd_t snap;
    upd_t prev;
    always begin
        @(negedge clk);
        #2;
        cyc++;
        if (rst) begin
            pend = 0;
            pop_due = 0;
            pop_off = 0;
            pop_cyc = -1;
        end else begin
            if (bus.upd_valid || bus.s_next_desc_rd_en)
                chk("rd_en_upd_valid_excl", 128'(bus.upd_valid && bus.s_next_desc_rd_en), 128'h0);
            if (pop_off) begin
                chk("pop_one_cycle", 128'(bus.s_next_desc_rd_en), 128'h0);
                pop_off = 0;
            end
            if (pop_due) begin
                chk("pop_en", 128'(bus.s_next_desc_rd_en), 128'h1);
                chk("pop_id", 128'(bus.s_next_desc_rd_id), 128'(exp_pop_id));
                pop_due = 0;
                pop_off = 1;
                pop_cyc = cyc;
            end else if (bus.s_next_desc_rd_en) begin
                chk("pop_unexpected", 128'(bus.s_next_desc_rd_en), 128'h0);
            end
            if (bus.s_poll_id != 9'h0 && pop_cyc >= 0) begin
                if (en_steady) chk("hold_gap", 128'(cyc - pop_cyc), 128'd4);
                pop_cyc = -1;
            end
            if (bus.upd_valid) begin
                if (pend) begin
                    chk("stable_id", 128'(bus.upd_id), 128'(prev.id));
                    chk("stable_seq", 128'(bus.upd_seq), 128'(prev.seq));
                    chk("stable_desc", bus.upd_desc, prev.desc);
                    chk("stable_dv", 128'(bus.upd_desc_valid), 128'(prev.dv));
                end else if (exp_q.size() == 0) begin
                    chk("upd_unexpected", 128'(bus.upd_valid), 128'h0);
                end else begin
                    snap = exp_q.pop_front();
                    chk("upd_id", 128'(bus.upd_id), 128'(snap.id));
                    chk("upd_seq", 128'(bus.upd_seq), 128'(snap.seq));
                    chk("upd_desc", bus.upd_desc, snap.desc);
                    chk("upd_desc_valid", 128'(bus.upd_desc_valid), 128'(snap.dv));
                    pend = 1;
                end
                prev = {bus.upd_id, bus.upd_seq, bus.upd_desc, bus.upd_desc_valid};
                if (pend && bus.upd_rdy) begin
                    pend = 0;
                    if (snap.dv) begin
                        pop_due = 1;
                        exp_pop_id = {2'b01, snap.id[6:0]};
                    end
                end
            end else if (pend) begin
                chk("upd_dropped", 128'(bus.upd_valid), 128'h1);
                pend = 0;
            end
        end
    end
    initial begin
        bit seen;
        bus.enable = 1'b0;
        bus.upd_rdy = 1'b0;
        for (int i = 0; i < NS; i++) begin
            data_seq[i] = 32'h2000;
            desc_seq[i] = 32'h200;
            head_v[i] = 1'b0;
            head_desc[i] = '0;
        end
        reset_model();
        #3;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        bus.enable = 1'b1;
        // Two quiet rounds: endpoints at reset values, nothing to report.
        repeat (60) step();
        data_seq[2] = 32'h2010;
        repeat (60) step();
        head_v[0] = 1'b1;
        head_desc[0] = {4{32'hA5A5A5A5}};
        repeat (60) step();
        data_seq[1] = 32'hFFFFFFF0;
        repeat (60) step();
        data_seq[1] = 32'h0;
        repeat (60) step();
        // Host stalls for 10 cycles on an update.
        rdy_mode = 1;
        data_seq[3] = data_seq[3] + 1;
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            step();
            seen = bus.upd_valid;
        end
        chk("stall_upd_seen", 128'(seen), 128'h1);
        repeat (10) step();
        rdy_mode = 0;
        repeat (40) step();
        mut_en = 1;
        repeat (1500) step();
        en_steady = 0;
        rand_en = 1;
        repeat (1000) step();
        rand_en = 0;
        mut_en = 0;
        bus.enable = 1'b1;
        // Reset while an update is waiting for the host.
        rdy_mode = 1;
        data_seq[0] = data_seq[0] + 5;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            seen = bus.upd_valid;
        end
        chk("rst_upd_seen", 128'(seen), 128'h1);
        #3;
        rst = 1'b1;
        #1;
        chk_outputs_zero("rst_mid");
        reset_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rdy_mode = 0;
        en_steady = 1;
        repeat (200) step();
        en_steady = 0;
        bus.enable = 1'b0;
        rdy_mode = 2;
        repeat (60) step();
        chk("queue_empty", 128'(exp_q.size()), 128'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
